// File: rtl/csr_rmw_bank.sv
// Custom/scratch CSR bank: NREG registers with RW/RS/RC read-modify-write access,
// per-bit write masks, illegal-access detection and a one-entry registered response.
module csr_rmw_bank #(
    parameter int                   XLEN      = 32,
    parameter int                   NREG      = 4,
    parameter logic [11:0]          BASE_ADDR = 12'h7C0,
    parameter logic [NREG*XLEN-1:0] WMASK     = {NREG*XLEN{1'b1}}
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_op,
    input  logic                 req_sel,
    input  logic [4:0]           req_imm,
    input  logic [XLEN-1:0]      req_rdata1,
    input  logic                 req_src_zero,
    input  logic [11:0]          req_addr,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [XLEN-1:0]      resp_cdata,
    output logic                 resp_illegal,
    output logic [NREG*XLEN-1:0] csr_q
);

    localparam logic [1:0] OP_RSV = 2'b00;
    localparam logic [1:0] OP_RW  = 2'b01;
    localparam logic [1:0] OP_RS  = 2'b10;

    function automatic logic [XLEN-1:0] rmw_calc(input logic [1:0] op,
                                                 input logic [XLEN-1:0] old_val,
                                                 input logic [XLEN-1:0] src_val);
        case (op)
            OP_RW:   rmw_calc = src_val;
            OP_RS:   rmw_calc = old_val | src_val;
            default: rmw_calc = old_val & ~src_val;
        endcase
    endfunction

    logic [XLEN-1:0] regs [NREG];
    logic [11:0]     offset_p0;
    logic            hit_p0;
    logic            wen_p0;
    logic            illegal_p0;
    logic            accept_p0;
    logic [XLEN-1:0] src_p0;
    logic [XLEN-1:0] old_p0;
    logic [XLEN-1:0] calc_p0;

    // Request decode, evaluated combinationally in the accept cycle
    assign req_ready  = ~resp_valid | resp_ready;
    assign accept_p0  = req_valid & req_ready;
    assign offset_p0  = req_addr - BASE_ADDR;
    assign hit_p0     = (req_addr >= BASE_ADDR) && (offset_p0 < 12'(NREG));
    assign src_p0     = req_sel ? {{(XLEN-5){1'b0}}, req_imm} : req_rdata1;
    // RS/RC with a zero source field are pure reads and may target read-only space
    assign wen_p0     = (req_op == OP_RW) | ~req_src_zero;
    assign illegal_p0 = ~hit_p0 | (req_op == OP_RSV) | (wen_p0 & (req_addr[11:10] == 2'b11));
    assign calc_p0    = rmw_calc(req_op, old_p0, src_p0);

    always_comb begin
        old_p0 = '0;
        for (int i = 0; i < NREG; i++) begin
            if (offset_p0 == 12'(i)) old_p0 = regs[i];
        end
    end

    // Register update and response capture share the accept edge
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (accept_p0 & ~illegal_p0 & wen_p0) begin
            for (int i = 0; i < NREG; i++) begin
                if (offset_p0 == 12'(i))
                    regs[i] <= (old_p0 & ~WMASK[i*XLEN +: XLEN]) | (calc_p0 & WMASK[i*XLEN +: XLEN]);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            resp_valid   <= 1'b0;
            resp_cdata   <= '0;
            resp_illegal <= 1'b0;
        end else if (accept_p0) begin
            resp_valid   <= 1'b1;
            resp_cdata   <= illegal_p0 ? '0 : old_p0;
            resp_illegal <= illegal_p0;
        end else if (resp_ready) begin
            resp_valid   <= 1'b0;
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_q
        assign csr_q[g*XLEN +: XLEN] = regs[g];
    end

endmodule

// File: tb/tb_csr_rmw_bank.sv
// Bench for csr_rmw_bank: two instances (base 7C0 with a masked reg0, base C00 read-only space)
// driven with shared requests, checked against an array-based model of the CSR bank.
module tb_csr_rmw_bank;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         req_valid = 1'b0;
    logic [1:0]   req_op = 2'b00;
    logic         req_sel = 1'b0;
    logic [4:0]   req_imm = 5'd0;
    logic [31:0]  req_rdata1 = 32'd0;
    logic         req_src_zero = 1'b0;
    logic [11:0]  req_addr = 12'd0;
    logic         resp_ready = 1'b1;

    logic         req_ready_a, req_ready_b;
    logic         resp_valid_a, resp_valid_b;
    logic [31:0]  resp_cdata_a, resp_cdata_b;
    logic         resp_illegal_a, resp_illegal_b;
    logic [127:0] csr_q_a, csr_q_b;

    int total = 0;
    int passed = 0;

    logic [31:0] mdl    [2][4];
    logic [31:0] mask_m [2][4];
    logic [11:0] base_m [2];
    logic [31:0] exp_cdata [2];
    logic        exp_ill   [2];

    always #5 clock = ~clock;

    csr_rmw_bank #(.XLEN(32), .NREG(4), .BASE_ADDR(12'h7C0),
                   .WMASK({32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0000FFFF})) dut_a (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_a),
        .req_op(req_op), .req_sel(req_sel), .req_imm(req_imm), .req_rdata1(req_rdata1),
        .req_src_zero(req_src_zero), .req_addr(req_addr), .resp_valid(resp_valid_a),
        .resp_ready(resp_ready), .resp_cdata(resp_cdata_a), .resp_illegal(resp_illegal_a),
        .csr_q(csr_q_a));

    csr_rmw_bank #(.XLEN(32), .NREG(4), .BASE_ADDR(12'hC00)) dut_b (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_b),
        .req_op(req_op), .req_sel(req_sel), .req_imm(req_imm), .req_rdata1(req_rdata1),
        .req_src_zero(req_src_zero), .req_addr(req_addr), .resp_valid(resp_valid_b),
        .resp_ready(resp_ready), .resp_cdata(resp_cdata_b), .resp_illegal(resp_illegal_b),
        .csr_q(csr_q_b));

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [127:0] pack(input int d);
        logic [127:0] p;
        for (int r = 0; r < 4; r++) p[r*32 +: 32] = mdl[d][r];
        return p;
    endfunction

    task automatic clear_model();
        for (int d = 0; d < 2; d++)
            for (int r = 0; r < 4; r++) mdl[d][r] = 32'd0;
    endtask

    task automatic model_step(input logic [1:0] op, input logic sel, input logic [4:0] imm,
                              input logic [31:0] rd1, input logic sz, input logic [11:0] addr);
        int          off;
        bit          hit, wen, ill;
        logic [31:0] src, old, nv;
        src = sel ? {27'd0, imm} : rd1;
        for (int d = 0; d < 2; d++) begin
            off = int'(addr) - int'(base_m[d]);
            hit = (off >= 0) && (off < 4);
            old = hit ? mdl[d][off[1:0]] : 32'd0;
            wen = (op == 2'd1) || !sz;
            ill = !hit || (op == 2'd0) || (wen && addr >= 12'hC00);
            exp_cdata[d] = ill ? 32'd0 : old;
            exp_ill[d]   = ill;
            if (!ill && wen) begin
                if (op == 2'd1)      nv = src;
                else if (op == 2'd2) nv = old | src;
                else                 nv = old & ~src;
                mdl[d][off[1:0]] = (old & ~mask_m[d][off[1:0]]) | (nv & mask_m[d][off[1:0]]);
            end
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic sel, input logic [4:0] imm,
                         input logic [31:0] rd1, input logic sz, input logic [11:0] addr);
        req_valid = 1'b1; req_op = op; req_sel = sel; req_imm = imm;
        req_rdata1 = rd1; req_src_zero = sz; req_addr = addr;
    endtask

    task automatic do_req(input logic [1:0] op, input logic sel, input logic [4:0] imm,
                          input logic [31:0] rd1, input logic sz, input logic [11:0] addr);
        drive(op, sel, imm, rd1, sz, addr);
        resp_ready = 1'b1;
        #1;
        chk("req_ready_a", 128'(req_ready_a), 128'(1'b1));
        chk("req_ready_b", 128'(req_ready_b), 128'(1'b1));
        model_step(op, sel, imm, rd1, sz, addr);
        @(posedge clock); #1;
        chk("resp_valid_a", 128'(resp_valid_a), 128'(1'b1));
        chk("resp_valid_b", 128'(resp_valid_b), 128'(1'b1));
        chk("cdata_a", 128'(resp_cdata_a), 128'(exp_cdata[0]));
        chk("cdata_b", 128'(resp_cdata_b), 128'(exp_cdata[1]));
        chk("illegal_a", 128'(resp_illegal_a), 128'(exp_ill[0]));
        chk("illegal_b", 128'(resp_illegal_b), 128'(exp_ill[1]));
        chk("csr_q_a", csr_q_a, pack(0));
        chk("csr_q_b", csr_q_b, pack(1));
    endtask

    task automatic idle();
        req_valid = 1'b0; resp_ready = 1'b1;
        @(posedge clock); #1;
        chk("idle_valid_a", 128'(resp_valid_a), 128'(1'b0));
        chk("idle_valid_b", 128'(resp_valid_b), 128'(1'b0));
    endtask

    task automatic do_reset();
        reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        clear_model();
        chk("rst_valid_a", 128'(resp_valid_a), 128'(1'b0));
        chk("rst_cdata_a", 128'(resp_cdata_a), 128'(32'd0));
        chk("rst_illegal_a", 128'(resp_illegal_a), 128'(1'b0));
        chk("rst_csr_q_a", csr_q_a, 128'd0);
        chk("rst_csr_q_b", csr_q_b, 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] held_cdata;
        logic [11:0] ra;
        base_m[0] = 12'h7C0;
        base_m[1] = 12'hC00;
        for (int r = 0; r < 4; r++) begin
            mask_m[0][r] = (r == 0) ? 32'h0000FFFF : 32'hFFFFFFFF;
            mask_m[1][r] = 32'hFFFFFFFF;
        end
        clear_model();
        repeat (2) @(posedge clock);
        #1;
        do_reset();

        // Write then read back
        do_req(2'd1, 1'b0, 5'd0, 32'hDEADBEEF, 1'b0, 12'h7C1);
        chk("rw_first_cdata", 128'(resp_cdata_a), 128'(32'd0));
        do_req(2'd2, 1'b0, 5'd0, 32'd0, 1'b1, 12'h7C1);
        chk("readback_cdata", 128'(resp_cdata_a), 128'(32'hDEADBEEF));
        chk("readback_q", 128'(csr_q_a[63:32]), 128'(32'hDEADBEEF));

        // Set/clear with immediate and register source
        do_req(2'd1, 1'b0, 5'd0, 32'h000000F0, 1'b0, 12'h7C2);
        do_req(2'd2, 1'b1, 5'h0F, 32'hFFFFFFFF, 1'b0, 12'h7C2);
        chk("rs_cdata", 128'(resp_cdata_a), 128'(32'h000000F0));
        chk("rs_reg", 128'(csr_q_a[95:64]), 128'(32'h000000FF));
        do_req(2'd3, 1'b0, 5'd0, 32'h00000011, 1'b0, 12'h7C2);
        chk("rc_cdata", 128'(resp_cdata_a), 128'(32'h000000FF));
        chk("rc_reg", 128'(csr_q_a[95:64]), 128'(32'h000000EE));
        do_req(2'd2, 1'b0, 5'd0, 32'hFFFFFFFF, 1'b1, 12'h7C2);
        chk("rs_zero_reg", 128'(csr_q_a[95:64]), 128'(32'h000000EE));
        chk("rs_zero_illegal", 128'(resp_illegal_a), 128'(1'b0));

        // Write mask and illegal accesses
        do_req(2'd1, 1'b0, 5'd0, 32'hFFFFFFFF, 1'b0, 12'h7C0);
        chk("wmask_reg0", 128'(csr_q_a[31:0]), 128'(32'h0000FFFF));
        do_req(2'd1, 1'b0, 5'd0, 32'h12345678, 1'b0, 12'h7C4);
        chk("out_of_range_ill", 128'(resp_illegal_a), 128'(1'b1));
        do_req(2'd0, 1'b0, 5'd0, 32'h12345678, 1'b0, 12'h7C1);
        chk("op00_ill", 128'(resp_illegal_a), 128'(1'b1));
        chk("op00_cdata", 128'(resp_cdata_a), 128'(32'd0));

        // Read-only space
        do_req(2'd1, 1'b0, 5'd0, 32'h00000005, 1'b0, 12'hC00);
        chk("ro_write_ill", 128'(resp_illegal_b), 128'(1'b1));
        do_req(2'd2, 1'b0, 5'd0, 32'h00000005, 1'b1, 12'hC00);
        chk("ro_read_legal", 128'(resp_illegal_b), 128'(1'b0));
        idle();

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 3))
                0: ra = 12'h7C0 + 12'($urandom_range(0, 5));
                1: ra = 12'hC00 + 12'($urandom_range(0, 5));
                2: ra = 12'($urandom);
                default: ra = 12'h7BE + 12'($urandom_range(0, 3));
            endcase
            do_req(2'($urandom), 1'($urandom), 5'($urandom), $urandom,
                   ($urandom_range(0, 3) == 0), ra);
            if ($urandom_range(0, 7) == 0) idle();
        end

        // Stall: response held while the next request waits
        do_reset();
        do_req(2'd1, 1'b0, 5'd0, 32'hAAAA5555, 1'b0, 12'h7C2);
        held_cdata = exp_cdata[0];
        drive(2'd1, 1'b0, 5'd0, 32'd1, 1'b0, 12'h7C0);
        resp_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #1;
            chk("stall_ready", 128'(req_ready_a), 128'(1'b0));
            @(posedge clock); #1;
            chk("stall_valid", 128'(resp_valid_a), 128'(1'b1));
            chk("stall_cdata", 128'(resp_cdata_a), 128'(held_cdata));
            chk("stall_q", csr_q_a, pack(0));
        end
        do_req(2'd1, 1'b0, 5'd0, 32'd1, 1'b0, 12'h7C0);
        chk("b2b_first", 128'(resp_cdata_a), 128'(32'd0));
        do_req(2'd2, 1'b0, 5'd0, 32'd2, 1'b0, 12'h7C0);
        chk("b2b_second", 128'(resp_cdata_a), 128'(32'd1));
        chk("b2b_reg", 128'(csr_q_a[31:0]), 128'(32'd3));

        // Reset during a stall with a request pending
        drive(2'd1, 1'b0, 5'd0, 32'h0BADF00D, 1'b0, 12'h7C3);
        resp_ready = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
        clear_model();
        chk("mid_rst_valid_a", 128'(resp_valid_a), 128'(1'b0));
        chk("mid_rst_valid_b", 128'(resp_valid_b), 128'(1'b0));
        chk("mid_rst_q_a", csr_q_a, pack(0));
        idle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
